// File: rtl/cache_types_pkg.sv
// Shared cache-side types: initiator FSM states, block storage type and the
// block address alignment helper used by the memory port initiator.
package cache_types;

  localparam int unsigned CACHE_BLOCKS = 4;
  localparam int unsigned WORD_BITS    = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    GAP,
    FILL,
    RESP
  } mem_init_state_t;

  typedef logic [CACHE_BLOCKS-1:0][WORD_BITS-1:0] block_t;

  // Clears the byte-in-word and word-in-block offset bits of an address.
  function automatic logic [31:0] block_align(input logic [31:0]  addr,
                                              input int unsigned  blocks = CACHE_BLOCKS);
    logic [31:0] mask;
    mask = ~((32'(blocks) << 2) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_port_initiator_timer.sv
// Stall counter for one memory transfer: clears between transfers, counts
// busy cycles and flags the busy cycle that brings the count to MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(MAX_WAIT))) begin
      count <= count + 1'b1;
    end
  end

  // Asserted in the busy cycle whose edge would make the count reach MAX_WAIT.
  assign expired = enable && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_initiator.sv
// Cache-side memory port initiator: optional dirty-victim writeback followed
// by a line fill, with a per-transfer stall timeout reported as resp_err.
module mem_port_initiator
  import cache_types::*;
#(
  parameter int unsigned BLOCKS   = CACHE_BLOCKS,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_dirty,
  input  logic [31:0]          req_wb_addr,
  input  logic [BLOCKS*32-1:0] req_wb_block,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BLOCKS*32-1:0] resp_block,
  output logic                 resp_err,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic                 mem_we,
  output logic [BLOCKS*32-1:0] mem_write_block,
  input  logic [BLOCKS*32-1:0] mem_read_block,
  input  logic                 mem_miss
);

  localparam int unsigned BW = BLOCKS * 32;

  if ((BLOCKS < 2) || (BLOCKS > 16) || ((BLOCKS & (BLOCKS - 1)) != 0)) begin : g_bad_blocks
    $error("BLOCKS must be a power of two in 2..16");
  end
  if (MAX_WAIT < 8) begin : g_bad_wait
    $error("MAX_WAIT must be at least 8");
  end

  mem_init_state_t state, state_nxt;

  logic [31:0]   fill_addr;
  logic [31:0]   wb_addr;
  logic [BW-1:0] wb_block;
  logic          in_xfer;
  logic          timeout;
  logic          accept;

  assign in_xfer = (state == WB) || (state == FILL);
  assign accept  = (state == IDLE) && req_valid;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_xfer),
    .enable  (in_xfer && mem_miss),
    .expired (timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An aborted writeback goes straight to RESP; the fill is never attempted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = req_dirty ? WB : FILL;
      WB: begin
        if (!mem_miss)    state_nxt = GAP;
        else if (timeout) state_nxt = RESP;
      end
      GAP:  state_nxt = FILL;
      FILL: if (!mem_miss || timeout) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_addr  <= '0;
      wb_addr    <= '0;
      wb_block   <= '0;
      resp_block <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        fill_addr <= block_align(req_addr, BLOCKS);
        wb_addr   <= block_align(req_wb_addr, BLOCKS);
        wb_block  <= req_wb_block;
      end
      if ((state == FILL) && !mem_miss) begin
        resp_block <= mem_read_block;
        resp_err   <= 1'b0;
      end else if (timeout) begin
        resp_block <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_write_block = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      WB: begin
        mem_req         = 1'b1;
        mem_we          = 1'b1;
        mem_addr        = wb_addr;
        mem_write_block = wb_block;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: a wait-state memory responder plus a
// transaction-level model of expected data, latency and bus activity.
module tb_mem_port_initiator;

  localparam int BLK  = 4;
  localparam int BW   = BLK * 32;
  localparam int MAXW = 8;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_dirty;
  logic [31:0]   req_wb_addr;
  logic [BW-1:0] req_wb_block;
  logic          resp_valid;
  logic          resp_ready;
  logic [BW-1:0] resp_block;
  logic          resp_err;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_write_block;
  logic [BW-1:0] mem_read_block;
  logic          mem_miss;

  mem_port_initiator #(
    .BLOCKS   (BLK),
    .MAX_WAIT (MAXW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_dirty       (req_dirty),
    .req_wb_addr     (req_wb_addr),
    .req_wb_block    (req_wb_block),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_block      (resp_block),
    .resp_err        (resp_err),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_write_block (mem_write_block),
    .mem_read_block  (mem_read_block),
    .mem_miss        (mem_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Responder: 4KB word memory, wait_states busy cycles per transfer.
  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [BW-1:0] data;
  } xfer_t;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  xfer_t       xfers [$];
  int          wait_states = 3;
  int          rcnt;

  assign mem_miss = mem_req && (rcnt < wait_states);

  always_comb begin
    mem_read_block = {BLK{32'hDEAD_BEEF}};
    if (mem_req && !mem_miss)
      for (int k = 0; k < BLK; k++)
        mem_read_block[k*32 +: 32] = mem[(int'(mem_addr[11:2]) + k) % 1024];
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) rcnt <= 0;
    else if (!mem_req) rcnt <= 0;
    else if (mem_miss) rcnt <= rcnt + 1;
    else begin
      rcnt <= 0;
      xfers.push_back('{we: mem_we, addr: mem_addr, data: mem_write_block});
      if (mem_we)
        for (int k = 0; k < BLK; k++)
          mem[(int'(mem_addr[11:2]) + k) % 1024] <= mem_write_block[k*32 +: 32];
    end
  end

  // Bus monitor: a completed transfer must be followed by a low mem_req cycle.
  bit done_prev  = 1'b0;
  int req_cycles = 0;
  int read_cycles = 0;
  always @(negedge clock) begin
    if (done_prev) check("mem_req_gap", mem_req, 1'b0);
    done_prev = mem_req && !mem_miss;
    if (mem_req) req_cycles++;
    if (mem_req && !mem_we) read_cycles++;
  end

  function automatic int widx(input logic [31:0] a);
    return int'({a[11:4], 2'b00});
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:4], 4'b0000};
  endfunction

  task automatic do_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] wba,
                         input logic [BW-1:0] wbb, input int waits, input int hold,
                         input bit keep_valid);
    logic [BW-1:0] exp_blk;
    bit aborted;
    int seg, exp_lat, exp_req, exp_n, cyc, n, x0, r0, q0;
    aborted = (waits >= MAXW);
    seg     = aborted ? MAXW : waits + 1;
    if (dirty) begin
      exp_lat = aborted ? MAXW + 1 : 2 * seg + 2;
      exp_req = aborted ? MAXW : 2 * seg;
      exp_n   = aborted ? 0 : 2;
    end else begin
      exp_lat = seg + 1;
      exp_req = seg;
      exp_n   = aborted ? 0 : 1;
    end
    exp_blk = '0;
    if (!aborted) begin
      if (dirty)
        for (int k = 0; k < BLK; k++) ref_mem[widx(wba) + k] = wbb[k*32 +: 32];
      for (int k = 0; k < BLK; k++) exp_blk[k*32 +: 32] = ref_mem[widx(addr) + k];
    end
    wait_states = waits;
    x0 = xfers.size();
    r0 = req_cycles;
    q0 = read_cycles;
    req_addr = addr; req_dirty = dirty; req_wb_addr = wba; req_wb_block = wbb;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clock); #1; n++; end
    check("accept_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    if (!keep_valid) req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 400) begin @(posedge clock); #1; cyc++; end
    check("resp_latency", cyc, exp_lat);
    check("resp_err", resp_err, aborted);
    check("resp_block", resp_block, exp_blk);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin req_valid = 1'b1; req_addr = ~addr; end
      @(posedge clock); #1;
      req_valid = keep_valid;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_block", resp_block, exp_blk);
      check("hold_ready", req_ready, 1'b0);
      check("hold_mem_req", mem_req, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_released", resp_valid, 1'b0);
    check("idle_ready", req_ready, 1'b1);
    check("mem_req_cycles", req_cycles - r0, exp_req);
    check("fill_entered", read_cycles != q0, !(dirty && aborted));
    check("xfer_count", xfers.size() - x0, exp_n);
    if ((xfers.size() - x0 == exp_n) && (exp_n > 0)) begin
      if (dirty) begin
        check("wb_we", xfers[x0].we, 1'b1);
        check("wb_addr", xfers[x0].addr, align(wba));
        check("wb_data", xfers[x0].data, wbb);
      end
      check("fill_we", xfers[x0 + exp_n - 1].we, 1'b0);
      check("fill_addr", xfers[x0 + exp_n - 1].addr, align(addr));
    end
  endtask

  task automatic reset_mid_fill();
    int n;
    wait_states = 3;
    req_addr = 32'h0000_0480; req_dirty = 1'b0; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    check("pre_reset_mem_req", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    check("async_mem_req", mem_req, 1'b0);
    check("async_req_ready", req_ready, 1'b1);
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_reset_ready", req_ready, 1'b1);
    check("post_reset_valid", resp_valid, 1'b0);
    check("post_reset_mem_req", mem_req, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_dirty = 1'b0; req_wb_addr = '0; req_wb_block = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i) << 2;
      ref_mem[i] = 32'(i) << 2;
    end
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_write_block, '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_block", resp_block, '0);
    check("rst_resp_err", resp_err, 1'b0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    do_miss(32'h0000_0044, 1'b0, 32'h0, '0, 3, 0, 1'b0);
    do_miss(32'h0000_0100, 1'b1, 32'h0000_0208,
            {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 3, 0, 1'b0);
    do_miss(32'h0000_0200, 1'b0, 32'h0, '0, 3, 0, 1'b0);
    do_miss(32'h0000_0364, 1'b0, 32'h0, '0, 3, 5, 1'b0);
    do_miss(32'h0000_0520, 1'b0, 32'h0, '0, 1000, 0, 1'b0);
    do_miss(32'h0000_0600, 1'b1, 32'h0000_0300, {BLK{32'h5555_AAAA}}, 1000, 2, 1'b0);
    do_miss(32'h0000_0300, 1'b0, 32'h0, '0, 0, 0, 1'b0);
    do_miss(32'h0000_0704, 1'b1, 32'h0000_07F0, {BLK{32'h1234_5678}}, 7, 0, 1'b0);
    do_miss(32'h0000_0708, 1'b0, 32'h0, '0, 8, 0, 1'b0);
    reset_mid_fill();
    do_miss(32'h0000_0480, 1'b0, 32'h0, '0, 3, 0, 1'b0);
    do_miss(32'h0000_0840, 1'b0, 32'h0, '0, 2, 0, 1'b1);
    do_miss(32'h0000_0850, 1'b0, 32'h0, '0, 2, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      do_miss($urandom, 1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
              (t != 39) && ($urandom_range(0, 1) == 1));
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
